// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl : 8-source interrupt controller for the 6502 peripheral bus.
// Pending/enable/mode registers, a priority vector and a registered irq line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_ctrl #(
  parameter bit SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [1:0] addr,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] src,
  output logic       irq
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_SET     = 2'd3;

  logic [7:0] s;
  logic [7:0] prev;
  logic [7:0] pending;
  logic [7:0] enable;
  logic [7:0] mode;

  logic [7:0] rise;
  logic [7:0] req;
  logic [7:0] clr;
  logic [7:0] set;
  logic [7:0] act;
  logic [2:0] vec_idx;
  logic [7:0] vector;
  logic [7:0] rd_data;
  logic       wr;
  logic       rd;

  generate
    if (SYNC) begin : g_sync
      logic [7:0] sync1;
      logic [7:0] sync2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= src;
          sync2 <= sync1;
        end
      end

      assign s = sync2;
    end else begin : g_nosync
      assign s = src;
    end
  endgenerate

  assign wr   = cs & we;
  assign rd   = cs & ~we;
  assign rise = s & ~prev;
  assign req  = (mode & rise) | (~mode & s);
  assign clr  = (wr && addr == ADDR_PENDING) ? dbw : 8'h00;
  assign set  = (wr && addr == ADDR_SET)     ? dbw : 8'h00;
  assign act  = pending & enable;

  // Scan from the top down so the lowest set bit (highest priority) wins.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) vec_idx = i[2:0];
    end
  end

  assign vector = (act != 8'h00) ? {1'b1, 4'b0000, vec_idx} : 8'h00;

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_PENDING: rd_data = pending;
      ADDR_ENABLE:  rd_data = enable;
      ADDR_MODE:    rd_data = mode;
      ADDR_SET:     rd_data = vector;
      default:      rd_data = 8'h00;
    endcase
  end

  // Requests and software sets are OR'd in after the clear so they win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      irq     <= 1'b0;
      dbr     <= '0;
    end else begin
      prev    <= s;
      pending <= (pending & ~clr) | req | set;
      if (wr && addr == ADDR_ENABLE) enable <= dbw;
      if (wr && addr == ADDR_MODE)   mode   <= dbw;
      irq     <= |act;
      dbr     <= rd ? rd_data : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- 8-source interrupt controller on the 6502 peripheral bus. Consumes timer `shot` flags and other peripheral request lines.
- Latches requests into a pending register, masks them with an enable register and drives a single registered `irq` line to the CPU.
- Exposes a priority vector so the ISR finds the source in one read.
- Same bus protocol as the other peripherals: 2-bit address, `cs`, `we`, registered read data.

Parameters:
- SYNC, 1, 1 = two-flop synchronizer on each `src` bit (asynchronous sources); 0 = `src` used directly (sources already in the `clk` domain).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- dbr  output 8  data bus READ, registered
- dbw  input  8  data bus WRITE
- addr input  2  register select
- cs   input  1  chip select
- we   input  1  1 = write, 0 = read
- src  input  8  interrupt request lines, bit i = source i
- irq  output 1  interrupt request to CPU, active-high, registered

Behaviour:
- Reset values: `dbr`=0, `irq`=0, PENDING=0, ENABLE=0, MODE=0 (all level), synchronizer and edge-history flops=0.
- Register map, writes (`cs & we`):
  - addr 0 PENDING: write-1-to-clear.
  - addr 1 ENABLE: full load.
  - addr 2 MODE: full load; bit=1 rising-edge, 0 level.
  - addr 3 SET: write-1-to-set PENDING (software trigger).
- Register map, reads (`cs & !we`):
  - addr 0: PENDING.
  - addr 1: ENABLE.
  - addr 2: MODE.
  - addr 3: VECTOR.
- VECTOR: let `act = PENDING & ENABLE`. If `act != 0`: bit7=1, bits2:0 = index of lowest set bit (source 0 = highest priority), bits6:3=0. If `act == 0`: 0x00.
- Read timing: `dbr` is loaded on the clock edge where `cs & !we` is sampled. Every other cycle `dbr` is loaded with 0. Reads have no side effects.
- Source path: `s` = synchronized `src` (2 flops if SYNC=1, wire if SYNC=0). `prev` <= `s` every cycle, independent of MODE. Edge `e[i] = s[i] & ~prev[i]`.
- Request term: `req[i] = MODE[i] ? e[i] : s[i]`.
- Per-edge PENDING update: `PENDING <= (PENDING & ~clr) | req | set`.
  - `clr`/`set` are the W1C / SET write data, 0 when not writing that address.
  - Set beats clear: a request arriving in the same cycle as its W1C leaves the bit pending.
- Level-mode bits: W1C while the source is still high re-sets the bit (held by `req`). The ISR must quiesce the source first.
- Edge-mode bits: one pulse/level rise sets the bit once. Held-high sources do not re-trigger.
- Switching a bit to edge mode while the source is high creates no spurious edge, because `prev` is already 1.
- ENABLE masks only `irq` and VECTOR, never PENDING capture. Disabled sources still latch.
- `irq` <= `|(PENDING & ENABLE)`, evaluated on register values before the current edge's update, so `irq` lags PENDING by one cycle.
- Latency from `src` sampled high at edge N:
  - SYNC=1: `s` valid after N+1, PENDING set at N+2, `irq` at N+3.
  - SYNC=0: PENDING at N, `irq` at N+1.
- Clearing the last active bit at edge M drops `irq` at M+1.
- Reset mid-operation: all state returns to reset values immediately (async); `irq` deasserts without waiting for a clock.

Test Plan:
- SYNC=0, write ENABLE=0x01, MODE=0x01; pulse `src[0]` for 1 cycle -> PENDING=0x01 next edge, `irq`=1 one edge later; VECTOR read = 0x80; W1C 0x01 to addr 0 -> `irq`=0 one cycle after clear.
- Level mode: ENABLE=0x04, hold `src[2]`=1, W1C 0x04 -> PENDING reads 0x04 again; drop `src[2]`, then W1C -> PENDING=0x00, `irq`=0.
- Priority: SET write 0xA0 with ENABLE=0xFF -> VECTOR=0x85; W1C 0x20 -> VECTOR=0x87; W1C 0x80 -> VECTOR=0x00, `irq`=0.
- Masking: ENABLE=0x00, edge on `src[3]` -> PENDING=0x08, `irq`=0, VECTOR=0x00; then ENABLE=0x08 -> `irq`=1 one cycle later.
- Simultaneous: edge-mode `src[1]` rises in the same cycle as W1C 0x02 -> PENDING bit 1 stays 1.
- SYNC=1 latency: `src[0]` rises before edge N (edge mode, enabled) -> PENDING at N+2, `irq` at N+3. Assert `rst` while `irq`=1 -> `irq`, `dbr`, all registers = 0 immediately.
